// File: rtl/demux_pkg.sv
// Shared constants for the 1:2 stream demux: default word width and channel codes.
package demux_pkg;
  localparam int   DEFAULT_DATA_W = 64;
  localparam logic CH_A           = 1'b0;
  localparam logic CH_B           = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is visible combinationally.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Equal index bits: same MSB means empty, differing MSB means full.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    head_o   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end
endmodule

// File: rtl/demux1t2_64_stream.sv
// Routes one input word stream to channel A or B by in_sel, each channel buffered
// by its own FIFO so a stalled consumer never blocks the other channel.
module demux1t2_64_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_data,
  input  logic              a_ready,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_data,
  input  logic              b_ready,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);
  // Handshake: a word moves on a rising edge exactly when valid and ready are both
  // high; in_ready looks only at the addressed FIFO, never at a_ready/b_ready.
  logic             full_a, full_b, empty_a, empty_b;
  logic             push_a, push_b;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  always_comb begin
    in_ready = rst_n && !((in_sel == CH_B) ? full_b : full_a);
    push_a   = in_valid && in_ready && (in_sel == CH_A);
    push_b   = in_valid && in_ready && (in_sel == CH_B);
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    if (push_a) cnt_a_d = cnt_a_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (push_b) cnt_b_d = cnt_b_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_a),
    .push_data_i(in_data),
    .pop_i      (a_ready),
    .full_o     (full_a),
    .empty_o    (empty_a),
    .head_o     (a_data)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_b),
    .push_data_i(in_data),
    .pop_i      (b_ready),
    .full_o     (full_b),
    .empty_o    (empty_b),
    .head_o     (b_data)
  );

  assign a_valid = !empty_a;
  assign b_valid = !empty_b;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;
endmodule

// File: tb/tb_demux1t2_64_stream.sv
// Directed and randomized bench for demux1t2_64_stream (DEPTH=2, CNT_W=4).
module tb_demux1t2_64_stream;
  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_sel, in_ready;
  logic [DW-1:0] in_data;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];
  logic          sb_en = 1'b0;
  int            acc_cnt = 0;
  int            model_cnt_a = 0;
  int            model_cnt_b = 0;

  localparam logic [DW-1:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [DW-1:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [DW-1:0] A1 = 64'hA1A1_0000_0000_0001;
  localparam logic [DW-1:0] A2 = 64'hA2A2_0000_0000_0002;
  localparam logic [DW-1:0] A3 = 64'hA3A3_0000_0000_0003;
  localparam logic [DW-1:0] B1 = 64'hB1B1_0000_0000_0001;

  demux1t2_64_stream #(.DATA_W(DW), .DEPTH(2), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_sel  (in_sel),
    .in_data (in_data),
    .in_ready(in_ready),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic sel, input logic [DW-1:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor, sampled at the falling edge
  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (in_sel) begin
          exp_b_q.push_back(in_data);
          model_cnt_b = (model_cnt_b + 1) % 16;
        end else begin
          exp_a_q.push_back(in_data);
          model_cnt_a = (model_cnt_a + 1) % 16;
        end
      end
      if (a_valid && a_ready) begin
        if (exp_a_q.size() == 0) check("sb_a_unexpected", {63'd0, a_valid}, 64'd0);
        else check("sb_a_order", a_data, exp_a_q.pop_front());
      end
      if (b_valid && b_ready) begin
        if (exp_b_q.size() == 0) check("sb_b_unexpected", {63'd0, b_valid}, 64'd0);
        else check("sb_b_order", b_data, exp_b_q.pop_front());
      end
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;

    // 1. reset values, then async reset with two words buffered in A
    #12;
    check("rst_a_valid", {63'd0, a_valid}, 64'd0);
    check("rst_b_valid", {63'd0, b_valid}, 64'd0);
    check("rst_a_data", a_data, 64'd0);
    check("rst_b_data", b_data, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    drive(1'b1, 1'b0, W1); step();
    drive(1'b1, 1'b0, W2); step();
    drive(1'b0, 1'b0, '0);
    check("t1_a_valid_pre", {63'd0, a_valid}, 64'd1);
    check("t1_cnt_a_pre", {60'd0, cnt_a}, 64'd2);
    #2 rst_n = 1'b0; #1;
    check("t1_async_a_valid", {63'd0, a_valid}, 64'd0);
    check("t1_async_cnt_a", {60'd0, cnt_a}, 64'd0);
    check("t1_async_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("t1_release_in_ready", {63'd0, in_ready}, 64'd1);
    step();

    // 2. routing with both consumers ready
    a_ready = 1'b1; b_ready = 1'b1;
    drive(1'b1, 1'b0, W1);
    check("t2_in_ready_a", {63'd0, in_ready}, 64'd1);
    step();
    drive(1'b1, 1'b1, W2);
    check("t2_a_valid", {63'd0, a_valid}, 64'd1);
    check("t2_a_data", a_data, W1);
    check("t2_b_valid_before", {63'd0, b_valid}, 64'd0);
    step();
    drive(1'b0, 1'b0, '0);
    check("t2_b_valid", {63'd0, b_valid}, 64'd1);
    check("t2_b_data", b_data, W2);
    check("t2_a_popped", {63'd0, a_valid}, 64'd0);
    check("t2_cnt_a", {60'd0, cnt_a}, 64'd1);
    check("t2_cnt_b", {60'd0, cnt_b}, 64'd1);
    step();
    check("t2_b_popped", {63'd0, b_valid}, 64'd0);

    // 3. backpressure on A does not block B
    a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b1, 1'b0, A1);
    check("t3_rdy_1", {63'd0, in_ready}, 64'd1);
    step();
    drive(1'b1, 1'b0, A2);
    check("t3_rdy_2", {63'd0, in_ready}, 64'd1);
    step();
    drive(1'b1, 1'b0, A3);
    check("t3_rdy_3_full", {63'd0, in_ready}, 64'd0);
    check("t3_a_head", a_data, A1);
    drive(1'b1, 1'b1, B1);
    check("t3_rdy_b", {63'd0, in_ready}, 64'd1);
    step();
    drive(1'b0, 1'b0, '0);
    check("t3_b_data", b_data, B1);
    check("t3_a_held", a_data, A1);
    check("t3_cnt_a", {60'd0, cnt_a}, 64'd3);
    check("t3_cnt_b", {60'd0, cnt_b}, 64'd2);
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    check("t3_b_drained", {63'd0, b_valid}, 64'd0);

    // 4. A full: pop and refused push in the same cycle, then accept
    check("t4_a_head", a_data, A1);
    a_ready = 1'b1;
    drive(1'b1, 1'b0, A3);
    check("t4_rdy_full", {63'd0, in_ready}, 64'd0);
    step();
    check("t4_a_second", a_data, A2);
    check("t4_rdy_after_pop", {63'd0, in_ready}, 64'd1);
    check("t4_cnt_a_refused", {60'd0, cnt_a}, 64'd3);
    step();
    drive(1'b0, 1'b0, '0);
    check("t4_a_third", a_data, A3);
    check("t4_a_valid", {63'd0, a_valid}, 64'd1);
    check("t4_cnt_a", {60'd0, cnt_a}, 64'd4);
    step();
    check("t4_a_empty", {63'd0, a_valid}, 64'd0);
    a_ready = 1'b0;

    // 5. counter wrap with CNT_W=4: 17 words to B
    pulse_reset();
    b_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 64'(i) + 64'hBB00);
      if (in_ready !== 1'b1) check("t5_rdy", {63'd0, in_ready}, 64'd1);
      step();
    end
    drive(1'b0, 1'b0, '0);
    check("t5_cnt_b_wrap", {60'd0, cnt_b}, 64'd1);
    check("t5_cnt_a", {60'd0, cnt_a}, 64'd0);
    step();

    // 6. randomized traffic against the scoreboard
    pulse_reset();
    sb_en = 1'b1;
    cyc = 0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      a_ready = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            {$urandom, $urandom});
      step();
      cyc++;
    end
    drive(1'b0, 1'b0, '0);
    a_ready = 1'b1; b_ready = 1'b1;
    repeat (6) step();
    check("t6_accepted", 64'(acc_cnt), 64'd10000);
    check("t6_a_leftover", 64'(exp_a_q.size()), 64'd0);
    check("t6_b_leftover", 64'(exp_b_q.size()), 64'd0);
    check("t6_cnt_a", {60'd0, cnt_a}, 64'(model_cnt_a));
    check("t6_cnt_b", {60'd0, cnt_b}, 64'(model_cnt_b));
    sb_en = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
